// File: rtl/img_pkg.sv
// Shared definitions for the image-analysis pipeline: frame markers,
// chain-code byte tag, packer state encoding and coordinate width.
package img_pkg;

  localparam int         COORD_W   = 6;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_BYTE  = 8'h5A;
  localparam logic [4:0] CODE_TAG  = 5'b00010;

  typedef enum logic [3:0] {
    PK_IDLE,
    PK_HDR_SYNC,
    PK_HDR_X,
    PK_HDR_Y,
    PK_CODES,
    PK_TR_CNT,
    PK_TR_AHI,
    PK_TR_ALO,
    PK_TR_PER,
    PK_TR_STAT,
    PK_TR_END
  } pk_state_e;

  // A chain code travels on the link tagged so the host can tell it from header bytes.
  function automatic logic [7:0] code_byte(input logic [2:0] code);
    return {CODE_TAG, code};
  endfunction

endpackage

// File: rtl/chain_fifo.sv
// Synchronous FIFO with a registered (block-RAM style) read port that
// always presents the current head on dout. The read address is chosen
// from the *next* read pointer, so after a pop the following entry is
// already staged one cycle later. A write landing on the address being
// read is forwarded through a small bypass register.
module chain_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  ram_rd_q;
  logic [W-1:0]  byp_data_q, byp_data_d;
  logic          byp_sel_q, byp_sel_d;
  logic          do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign dout  = byp_sel_q ? byp_data_q : ram_rd_q;

  // Pointer / occupancy update; clear wins over any push or pop.
  always_comb begin
    do_push    = push && !full && !clr;
    do_pop     = pop && !empty && !clr;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // The RAM read sees the old contents on a same-address write, so forward din.
    byp_sel_d  = do_push && (wr_ptr_q == rd_ptr_d);
    byp_data_d = din;
  end

  // Storage array with registered read of the next head address.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
    ram_rd_q <= mem[rd_ptr_d];
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule

// File: rtl/chain_code_packer.sv
// Buffers chain codes from the boundary encoder and, on Done, emits one
// framed byte stream (header, codes, trailer) over a valid/ready link.
// The state names the byte currently held in the output register; each
// handshake loads the next byte, so a ready sink sees one byte per cycle.
module chain_code_packer
  import img_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [2:0]         Code,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [11:0]        Area,
  input  logic [7:0]         Permiter,
  input  logic               Done,
  input  logic               Error,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               busy
);

  pk_state_e          state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               valid_q, valid_d;
  logic               code_ready_q, code_ready_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [11:0]        area_q, area_d;
  logic [7:0]         per_q, per_d;
  logic               err_q, err_d;

  logic       fifo_push, fifo_pop, fifo_clr;
  logic       fifo_full, fifo_empty;
  logic [2:0] fifo_dout;
  logic       hs, accept;

  chain_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (3)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (Code),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign code_ready = code_ready_q;
  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = (state_q != PK_IDLE);

  // Next-state, next-byte and buffering decisions.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    x_d       = x_q;
    y_d       = y_q;
    area_d    = area_q;
    per_d     = per_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;

    hs        = valid_q && byte_ready;
    // code_ready_q is high exactly when idle, so it also gates acceptance.
    accept    = code_ready_q && code_valid;
    fifo_push = accept && !fifo_full;
    if (accept && fifo_full) ovf_d = 1'b1;
    if (fifo_push && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;

    case (state_q)
      PK_IDLE: begin
        valid_d = 1'b0;
        if (Done) begin
          x_d     = start_x;
          y_d     = start_y;
          area_d  = Area;
          per_d   = Permiter;
          err_d   = Error;
          state_d = PK_HDR_SYNC;
          byte_d  = SYNC_BYTE;
          valid_d = 1'b1;
        end
      end
      PK_HDR_SYNC: if (hs) begin
        state_d = PK_HDR_X;
        byte_d  = {2'b00, x_q};
      end
      PK_HDR_X: if (hs) begin
        state_d = PK_HDR_Y;
        byte_d  = {2'b00, y_q};
      end
      PK_HDR_Y, PK_CODES: if (hs) begin
        if (!fifo_empty) begin
          state_d  = PK_CODES;
          byte_d   = code_byte(fifo_dout);
          fifo_pop = 1'b1;
        end else begin
          state_d  = PK_TR_CNT;
          byte_d   = cnt_q;
        end
      end
      PK_TR_CNT: if (hs) begin
        state_d = PK_TR_AHI;
        byte_d  = {4'h0, area_q[11:8]};
      end
      PK_TR_AHI: if (hs) begin
        state_d = PK_TR_ALO;
        byte_d  = area_q[7:0];
      end
      PK_TR_ALO: if (hs) begin
        state_d = PK_TR_PER;
        byte_d  = per_q;
      end
      PK_TR_PER: if (hs) begin
        state_d = PK_TR_STAT;
        byte_d  = {6'b0, err_q, ovf_q};
      end
      PK_TR_STAT: if (hs) begin
        state_d = PK_TR_END;
        byte_d  = END_BYTE;
      end
      PK_TR_END: if (hs) begin
        state_d  = PK_IDLE;
        byte_d   = 8'h00;
        valid_d  = 1'b0;
        cnt_d    = 8'h00;
        ovf_d    = 1'b0;
        fifo_clr = 1'b1;
      end
      default: begin
        state_d = PK_IDLE;
        valid_d = 1'b0;
      end
    endcase

    code_ready_d = (state_d == PK_IDLE);
  end

  // All packer state and the registered link outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PK_IDLE;
      byte_q       <= 8'h00;
      valid_q      <= 1'b0;
      code_ready_q <= 1'b0;
      cnt_q        <= 8'h00;
      ovf_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      area_q       <= '0;
      per_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      valid_q      <= valid_d;
      code_ready_q <= code_ready_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      x_q          <= x_d;
      y_q          <= y_d;
      area_q       <= area_d;
      per_q        <= per_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_chain_code_packer.sv
// Directed bench for chain_code_packer: builds each expected frame by hand
// and compares the captured byte stream plus handshake/status outputs.
module tb_chain_code_packer;

  logic       Clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] Code;
  logic [5:0] start_x, start_y;
  logic [11:0] Area;
  logic [7:0] Permiter;
  logic       Done, Error;
  logic [7:0] byte_out;
  logic       byte_valid, byte_ready, busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int cyc;

  chain_code_packer dut (
    .Clk        (Clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .Code       (Code),
    .start_x    (start_x),
    .start_y    (start_y),
    .Area       (Area),
    .Permiter   (Permiter),
    .Done       (Done),
    .Error      (Error),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_code(input logic [2:0] c);
    @(negedge Clk);
    code_valid = 1'b1;
    Code       = c;
  endtask

  task automatic do_done(input logic [5:0] x, input logic [5:0] y, input logic [11:0] a,
                         input logic [7:0] p, input logic e, input bit with_code,
                         input logic [2:0] c);
    @(negedge Clk);
    code_valid = with_code;
    Code       = c;
    start_x    = x;
    start_y    = y;
    Area       = a;
    Permiter   = p;
    Error      = e;
    Done       = 1'b1;
  endtask

  // Collects one frame; optionally toggles ready and pulses a stray Done.
  task automatic run_frame(input string name, input bit toggle, input int dpulse_at,
                           output int cycles);
    int it;
    bit rdy, phase, stall;
    logic [7:0] prev;
    got_q.delete();
    it = 0; phase = 1'b1; stall = 1'b0; prev = 8'h00;
    while (got_q.size() < exp_q.size() && it < 2000) begin
      @(negedge Clk);
      it++;
      code_valid = 1'b0;
      Done = (it == dpulse_at);
      if (it == dpulse_at) start_x = 6'h3F;
      if (it == 1) chk({name, "_first_valid"}, 32'(byte_valid), 32'd1);
      if (it == 2) begin
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_code_ready_lo"}, 32'(code_ready), 32'd0);
      end
      if (stall) begin
        chk({name, "_hold_valid"}, 32'(byte_valid), 32'd1);
        chk({name, "_hold_byte"}, 32'(byte_out), 32'(prev));
      end
      rdy = toggle ? phase : 1'b1;
      phase = !phase;
      byte_ready = rdy;
      if (byte_valid && rdy) got_q.push_back(byte_out);
      stall = byte_valid && !rdy;
      prev  = byte_out;
    end
    cycles = it;
    chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    @(negedge Clk);
    Done = 1'b0;
    byte_ready = 1'b1;
    chk({name, "_valid_after"}, 32'(byte_valid), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_code_ready_after"}, 32'(code_ready), 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    $display("%s: %0d bytes captured in %0d cycles", name, got_q.size(), cycles);
  endtask

  initial begin
    reset = 1'b0; code_valid = 1'b0; Code = 3'd0; start_x = '0; start_y = '0;
    Area = '0; Permiter = '0; Done = 1'b0; Error = 1'b0; byte_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code_ready", 32'(code_ready), 32'd0);
    @(negedge Clk); reset = 1'b1;
    @(negedge Clk);
    chk("post_rst_code_ready", 32'(code_ready), 32'd1);

    // T1: four codes, ready high throughout
    push_code(3'd0); push_code(3'd1); push_code(3'd2); push_code(3'd7);
    do_done(6'd3, 6'd5, 12'h123, 8'd4, 1'b0, 1'b0, 3'd0);
    exp_q = '{8'hA5, 8'h03, 8'h05, 8'h10, 8'h11, 8'h12, 8'h17,
              8'h04, 8'h01, 8'h23, 8'h04, 8'h00, 8'h5A};
    run_frame("t1", 1'b0, -1, cyc);
    chk("t1_cycles", 32'(cyc), 32'd13);

    // T2: same stimulus, ready toggling
    push_code(3'd0); push_code(3'd1); push_code(3'd2); push_code(3'd7);
    do_done(6'd3, 6'd5, 12'h123, 8'd4, 1'b0, 1'b0, 3'd0);
    run_frame("t2", 1'b1, -1, cyc);

    // T3: full FIFO plus one dropped code
    for (int i = 0; i < 256; i++) push_code(3'(i % 8));
    push_code(3'd5);
    do_done(6'd1, 6'd2, 12'hABC, 8'hFF, 1'b0, 1'b0, 3'd0);
    exp_q = '{8'hA5, 8'h01, 8'h02};
    for (int i = 0; i < 256; i++) exp_q.push_back(8'h10 | 8'(i % 8));
    exp_q.push_back(8'hFF); exp_q.push_back(8'h0A); exp_q.push_back(8'hBC);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h5A);
    run_frame("t3", 1'b0, -1, cyc);

    // T4: empty frame with Error set; overflow from T3 must be cleared
    do_done(6'd0, 6'd0, 12'h000, 8'h00, 1'b1, 1'b0, 3'd0);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h5A};
    run_frame("t4", 1'b0, -1, cyc);

    // T5: code arriving with Done; stray Done mid-frame
    push_code(3'd3);
    do_done(6'd2, 6'd4, 12'h010, 8'h02, 1'b0, 1'b1, 3'd6);
    exp_q = '{8'hA5, 8'h02, 8'h04, 8'h13, 8'h16, 8'h02, 8'h00, 8'h10,
              8'h02, 8'h00, 8'h5A};
    run_frame("t5", 1'b0, 6, cyc);

    // T6: reset during CODES, then a fresh frame
    push_code(3'd1); push_code(3'd2); push_code(3'd3);
    do_done(6'd1, 6'd1, 12'h001, 8'h01, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Done = 1'b0; code_valid = 1'b0; byte_ready = 1'b1;
    end
    chk("t6_in_codes", 32'(byte_out), 32'h11);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(byte_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_code_ready", 32'(code_ready), 32'd0);
    @(negedge Clk); reset = 1'b1;
    @(negedge Clk);
    chk("t6_idle_code_ready", 32'(code_ready), 32'd1);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_valid", 32'(byte_valid), 32'd0);
    push_code(3'd4); push_code(3'd5);
    do_done(6'd7, 6'd9, 12'h0FF, 8'h02, 1'b0, 1'b0, 3'd0);
    exp_q = '{8'hA5, 8'h07, 8'h09, 8'h14, 8'h15, 8'h02, 8'h00, 8'hFF,
              8'h02, 8'h00, 8'h5A};
    run_frame("t6", 1'b0, -1, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
